// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encodings,
// requester count and the rotating-priority search.
package rr_arbiter4_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Scan starting just after the last-served requester and wrap around,
  // so the last owner is considered only when nobody else is asking.
  function automatic pick_t rr_pick(input logic [0:NREQ-1] req, input logic [1:0] last);
    pick_t      p;
    logic [1:0] cand;
    p.found = 1'b0;
    p.idx   = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!p.found && req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four requesters (master side) and the
// arbiter (slave side).
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic [0:NREQ-1] req;
  logic            done;
  logic [0:NREQ-1] grant;
  logic [1:0]      grant_idx;
  logic            busy;
  logic            timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, busy, timeout
  );

endinterface

// File: rtl/rr_arbiter4_dec2to4.sv
// 2-to-4 one-hot decoder with enable; y_o[0] is the leftmost bit and is
// selected by w_i == 0.
module dec2to4 (
  input  logic [1:0] w_i,
  input  logic       en_i,
  output logic [0:3] y_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign y_o[gi] = en_i && (w_i == 2'(gi));
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with an optional hold timeout.
// Grant is decoded from registered state only; each release forces one idle cycle.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAXHOLD = 16,
  parameter int CW      = 5
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  rr_arbiter4_if.slave bus
);

  localparam bit            HOLD_EN   = (MAXHOLD != 0);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAXHOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAXHOLD - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          busy;
  pick_t         pick;
  logic          hold_hit;
  logic          release_w;

  assign pick      = rr_pick(bus.req, last_q);
  assign hold_hit  = HOLD_EN && (cnt_q == HOLD_LAST);
  assign release_w = bus.done || !bus.req[idx_q] || hold_hit;

  // State register
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick.found) state_d = S_GRANT;
      S_GRANT: if (release_w)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_GRANT);
  end

  // Owner index, last-served pointer, hold counter and timeout pulse
  always_comb begin
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick.found) begin
          idx_d = pick.idx;
          cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (release_w) begin
          last_d    = idx_q;
          cnt_d     = '0;
          // Flag only releases the counter alone forced
          timeout_d = hold_hit && !bus.done && bus.req[idx_q];
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      idx_q     <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  dec2to4 u_dec (
    .w_i  (idx_q),
    .en_i (busy),
    .y_o  (bus.grant)
  );

  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench: dut0 runs with a 4-cycle hold limit, dut1 with the
// timeout disabled; both see the same requests.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter4_if bus0 ();
  rr_arbiter4_if bus1 ();

  assign bus1.req  = bus0.req;
  assign bus1.done = bus0.done;

  rr_arbiter4 #(.MAXHOLD(4), .CW(3)) dut0 (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus0.slave)
  );

  rr_arbiter4 #(.MAXHOLD(0), .CW(5)) dut1 (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    if (obs === exp) $display("%0t %s = %0h", $time, tag, obs);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  logic [3:0] exp_g;

  initial begin
    resetn    = 1'b0;
    bus0.req  = 4'b0000;
    bus0.done = 1'b0;
    tick();
    tick();
    check("rst_grant",   {28'd0, bus0.grant}, 32'h0);
    check("rst_idx",     {30'd0, bus0.grant_idx}, 32'h0);
    check("rst_busy",    {31'd0, bus0.busy}, 32'h0);
    check("rst_timeout", {31'd0, bus0.timeout}, 32'h0);
    resetn = 1'b1;

    // Single requester 0, released by Done
    bus0.req = 4'b1000;
    tick();
    check("t1_grant", {28'd0, bus0.grant}, 32'h8);
    check("t1_idx",   {30'd0, bus0.grant_idx}, 32'h0);
    check("t1_busy",  {31'd0, bus0.busy}, 32'h1);
    bus0.done = 1'b1;
    tick();
    check("t1_rel_grant",   {28'd0, bus0.grant}, 32'h0);
    check("t1_rel_timeout", {31'd0, bus0.timeout}, 32'h0);
    bus0.done = 1'b0;
    bus0.req  = 4'b0000;
    tick();
    // Last=0 now, so requester 1 beats requester 0
    bus0.req = 4'b1100;
    tick();
    check("t1_last0_grant", {28'd0, bus0.grant}, 32'h4);
    bus0.done = 1'b1;
    tick();
    bus0.done = 1'b0;
    bus0.req  = 4'b0000;

    // All requesting, Done every third cycle: 0,1,2,3,0 with bubbles
    do_reset();
    bus0.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b1000 >> (k % 4);
      tick();
      check($sformatf("t2_grant%0d", k), {28'd0, bus0.grant}, {28'd0, exp_g});
      tick();
      check($sformatf("t2_hold%0d", k), {28'd0, bus0.grant}, {28'd0, exp_g});
      bus0.done = 1'b1;
      tick();
      check($sformatf("t2_bubble%0d", k), {28'd0, bus0.grant}, 32'h0);
      check($sformatf("t2_tmo%0d", k), {31'd0, bus0.timeout}, 32'h0);
      bus0.done = 1'b0;
    end
    bus0.req = 4'b0000;
    tick();

    // Hold timeout on requester 2
    do_reset();
    bus0.req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t3_grant%0d", k), {28'd0, bus0.grant}, 32'h2);
      check($sformatf("t3_tmo%0d", k), {31'd0, bus0.timeout}, 32'h0);
    end
    tick();
    check("t3_forced_grant", {28'd0, bus0.grant}, 32'h0);
    check("t3_forced_tmo",   {31'd0, bus0.timeout}, 32'h1);
    check("t3_forced_busy",  {31'd0, bus0.busy}, 32'h0);
    check("t3_nolimit_grant", {28'd0, bus1.grant}, 32'h2);
    check("t3_nolimit_tmo",   {31'd0, bus1.timeout}, 32'h0);
    tick();
    check("t3_regrant",     {28'd0, bus0.grant}, 32'h2);
    check("t3_regrant_tmo", {31'd0, bus0.timeout}, 32'h0);
    check("t3_nolimit_still", {28'd0, bus1.grant}, 32'h2);
    bus0.req = 4'b0000;
    tick();
    check("t3_withdraw_tmo",    {31'd0, bus0.timeout}, 32'h0);
    check("t3_nolimit_release", {28'd0, bus1.grant}, 32'h0);
    tick();

    // Owner 2 withdraws while 0 and 3 wait; no pre-emption meanwhile
    bus0.req = 4'b0010;
    tick();
    check("t4_grant2", {28'd0, bus0.grant}, 32'h2);
    bus0.req = 4'b1011;
    tick();
    check("t4_no_preempt", {28'd0, bus0.grant}, 32'h2);
    bus0.req = 4'b1001;
    tick();
    check("t4_rel_grant", {28'd0, bus0.grant}, 32'h0);
    check("t4_rel_tmo",   {31'd0, bus0.timeout}, 32'h0);
    check("t4_idx_hold",  {30'd0, bus0.grant_idx}, 32'h2);
    tick();
    check("t4_grant3", {28'd0, bus0.grant}, 32'h1);
    check("t4_idx3",   {30'd0, bus0.grant_idx}, 32'h3);
    bus0.done = 1'b1;
    tick();
    check("t4_bubble", {28'd0, bus0.grant}, 32'h0);
    bus0.done = 1'b0;
    tick();
    check("t4_grant0", {28'd0, bus0.grant}, 32'h8);
    bus0.done = 1'b1;
    tick();
    bus0.done = 1'b0;
    bus0.req  = 4'b0000;
    tick();

    // Reset during a grant of requester 1
    bus0.req = 4'b0100;
    tick();
    check("t5_grant1", {28'd0, bus0.grant}, 32'h4);
    resetn = 1'b0;
    tick();
    check("t5_rst_grant", {28'd0, bus0.grant}, 32'h0);
    check("t5_rst_busy",  {31'd0, bus0.busy}, 32'h0);
    check("t5_rst_idx",   {30'd0, bus0.grant_idx}, 32'h0);
    resetn   = 1'b1;
    bus0.req = 4'b1010;
    tick();
    check("t5_first0", {28'd0, bus0.grant}, 32'h8);
    bus0.done = 1'b1;
    tick();
    bus0.done = 1'b0;
    bus0.req  = 4'b0000;
    tick();

    // Done while idle has no effect
    bus0.done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t6_grant%0d", k), {28'd0, bus0.grant}, 32'h0);
      check($sformatf("t6_busy%0d", k),  {31'd0, bus0.busy}, 32'h0);
      check($sformatf("t6_tmo%0d", k),   {31'd0, bus0.timeout}, 32'h0);
    end
    bus0.done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
